// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter stepping once per prescaler tick, pulsing done at zero
module countdown_timer #(
  parameter int N = 20,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] load_val,
  input  logic         pause,
  output logic [W-1:0] data,
  output logic         busy,
  output logic         done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [N-1:0] presc, presc_n;
  logic [W-1:0] data_n;
  logic done_n, tick, run;
  assign run  = state == RUN && !pause;
  assign tick = run && &presc;
  always_comb begin
    state_n = state;
    data_n  = data;
    presc_n = presc;
    done_n  = 1'b0;
    if (start) begin
      data_n  = load_val;
      presc_n = '0;
      state_n = (load_val != '0) ? RUN : IDLE;
      done_n  = load_val == '0;
    end else if (run) begin
      presc_n = presc + 1'b1;
      data_n  = tick ? data - 1'b1 : data;
      state_n = (tick && data == W'(1)) ? IDLE : RUN;
      done_n  = tick && data == W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data  <= '0;
      presc <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      data  <= data_n;
      presc <= presc_n;
      busy  <= state_n == RUN;
      done  <= done_n;
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of countdown_timer with N=2
module tb_countdown_timer;
  logic clk = 1'b0;
  logic rst, start, pause;
  logic [3:0] load_val, data;
  logic busy, done;
  int n_checks = 0;
  int n_fail = 0;
  countdown_timer #(.N(2), .W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .load_val(load_val),
    .pause(pause), .data(data), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk3(input string tag, input int e, input int d, input int b, input int dn);
    check($sformatf("%s data e%0d", tag, e), int'(data), d);
    check($sformatf("%s busy e%0d", tag, e), int'(busy), b);
    check($sformatf("%s done e%0d", tag, e), int'(done), dn);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; load_val = 4'd0;
    step(); step();
    chk3("por", 0, 0, 0, 0);
    rst = 1'b0;
    step();
    chk3("idle", 0, 0, 0, 0);
    start = 1'b1; load_val = 4'd5;
    step();
    start = 1'b0;
    step(); step();
    chk3("pre_rst", 2, 5, 1, 0);
    rst = 1'b1;
    step();
    chk3("rst", 1, 0, 0, 0);
    step();
    rst = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step();
      chk3("post_rst", e, 0, 0, 0);
    end
    start = 1'b1; load_val = 4'd3;
    step();
    start = 1'b0;
    chk3("basic", 0, 3, 1, 0);
    for (int e = 1; e <= 13; e++) begin
      step();
      chk3("basic", e, (e >= 12) ? 0 : 3 - e / 4, int'(e < 12), int'(e == 12));
    end
    start = 1'b1; load_val = 4'd0;
    step();
    start = 1'b0;
    chk3("zero", 0, 0, 0, 1);
    step();
    chk3("zero", 1, 0, 0, 0);
    start = 1'b1; load_val = 4'd2;
    step();
    start = 1'b0;
    chk3("pause", 0, 2, 1, 0);
    for (int e = 1; e <= 14; e++) begin
      pause = e >= 2 && e <= 6;
      step();
      chk3("pause", e, (e < 9) ? 2 : (e < 13) ? 1 : 0, int'(e < 13), int'(e == 13));
    end
    pause = 1'b0;
    start = 1'b1; load_val = 4'd4;
    step();
    start = 1'b0;
    for (int e = 1; e <= 31; e++) begin
      start = e == 6;
      load_val = 4'd6;
      step();
      chk3("restart", e, (e < 4) ? 4 : (e < 6) ? 3 : 6 - (e - 6) / 4, int'(e < 30), int'(e == 30));
    end
    start = 1'b0;
    start = 1'b1; load_val = 4'd15;
    step();
    start = 1'b0;
    for (int e = 1; e <= 61; e++) begin
      step();
      chk3("max", e, 15 - e / 4, int'(e < 60), int'(e == 60));
    end
    start = 1'b1; load_val = 4'd2;
    for (int e = 0; e < 20; e++) begin
      step();
      chk3("hold", e, 2, 1, 0);
    end
    start = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      step();
      chk3("hold_end", e, (e < 4) ? 2 : (e < 8) ? 1 : 0, int'(e < 8), int'(e == 8));
    end
    pause = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      chk3("idle_pause", e, 0, 0, 0);
    end
    pause = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable 4-bit down-counter, the reverse of the free-running prescaled up-counter.
- Loaded with a start value, it decrements once per prescaler tick until it reaches zero, then raises a one-cycle done pulse.
- Used by game/robot sequencing logic for timed delays.
- Exposes its current count on `data` for LED display.

Parameters:
- N, 20, prescaler width; one tick every 2^N clk cycles (benches use N=2).
- W, 4, counter width of load_val and data.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  load/restart request, sampled on posedge clk.
- load_val  input  W  start value, sampled only when start=1.
- pause  input  1  freezes prescaler and count while high.
- data  output  W  current count (registered).
- busy  output  1  high while counting (RUN state).
- done  output  1  one-cycle pulse when the count reaches zero.

Behaviour:

Reset (rst=1 at a posedge, highest priority over every other input):
- state=IDLE, data=0, busy=0, done=0, prescaler=0.
- Reset mid-count aborts the count and produces no done pulse.

Prescaler:
- Internal N-bit counter, active only in RUN and only when pause=0.
- tick = prescaler==2^N-1 and pause=0.
- On tick the prescaler wraps to 0.
- The prescaler is cleared on every accepted start.

States: IDLE, RUN. All outputs are registered. done defaults to 0 every cycle unless set below.

IDLE:
- start=1, load_val!=0: data<=load_val, busy<=1, prescaler<=0, go to RUN.
- start=1, load_val==0: data<=0, done<=1 for one cycle, busy stays 0, stay in IDLE.
- start=0: hold data (0 after a completed count).

RUN:
- start=1 has priority over tick: data<=load_val, prescaler<=0, stay in RUN.
  - If load_val==0 on restart: data<=0, busy<=0, done<=1, go to IDLE.
- Else if tick and data>1: data<=data-1.
- Else if tick and data==1: data<=0, busy<=0, done<=1, go to IDLE.
- Else if pause=0: prescaler<=prescaler+1.
- If pause=1: prescaler, data and busy all hold.

Timing:
- If start is accepted at edge k with value L>0 and there is no pause, decrements land at edges k+2^N, k+2·2^N, …, k+L·2^N.
- At edge k+L·2^N: data=0, busy=0, done=1.
- done returns to 0 at the next edge.
- busy is high for exactly L·2^N cycles.

Boundaries:
- data never underflows; there is no decrement in IDLE.
- load_val=2^W-1 (15) counts the full range.
- Pause asserted in the same cycle as the would-be tick suppresses that tick; counting resumes seamlessly when pause drops.
- start held high continuously in RUN keeps reloading, so done never fires.
- pause in IDLE has no effect.

Test Plan (N=2):
- Reset: assert rst 2 cycles mid-count with data=5 -> next cycle data=0, busy=0, done=0; no done pulse follows.
- Basic count: start with load_val=3 at edge 0 -> data=3,2,1,0 at edges 0,4,8,12; busy high edges 0–11; done=1 only after edge 12.
- Zero load: start with load_val=0 in IDLE -> done=1 for one cycle, busy stays 0, data=0.
- Pause: load_val=2, pause high for 5 cycles starting at cycle 2 -> first decrement delayed 5 cycles (edge 9), done after edge 13; data holds during pause.
- Restart: load_val=4, then start with load_val=6 at edge 6 (data=3) -> data=6 at edge 6; prescaler restarts, so decrements land at edges 10,14,…; done after edge 30.
- Max/priority: load_val=15 -> done after edge 60. Separately, hold start=1 with load_val=2 for 20 cycles -> data stays 2 and done stays 0.
